cond_issue_stage: RTL
=====================

# cond_issue_stage

Issue/writeback stage directly upstream of the 16-bit `set_condition` comparator in the lab ALU datapath. It:

- accepts compare instructions over a valid/ready handshake;
- fetches both operands from an internal 8×16 register file and drives them, with the condition code, to the comparator;
- registers the 16-bit comparator result and writes it back to a destination register.

A side write port loads the register file. A side read port exposes it to the bench.

## Interface
Parameters
- `DW`, 16: data width. Must equal the comparator width.
- `NREG`, 8: register count. Address width is $clog2(NREG) = 3.

Ports
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  stage can accept an instruction.
- `instr_code`  in  3  condition: 000 LE, 001 LT, 010 GE, 011 GT, 100 EQ, 101 NE, 110/111 reserved.
- `instr_rs`, `instr_rt`, `instr_rd`  in  3 each  operand A, operand B and destination register indices.
- `ext_we`  in  1  external register write enable.
- `ext_waddr`  in  3  external write address.
- `ext_wdata`  in  16  external write data.
- `dbg_raddr`  in  3  debug read address.
- `dbg_rdata`  out  16  combinational read of `reg[dbg_raddr]`.
- `cmp_a`, `cmp_b`  out  16  operands to the comparator, registered.
- `cmp_code`  out  3  code to the comparator, registered.
- `cmp_c`  in  16  comparator result, combinational from `cmp_a`/`cmp_b`/`cmp_code`.
- `done`  out  1  one-cycle pulse, high while the writeback commits.
- `result`  out  16  last captured result; held until the next capture.
- `err`  out  1  one-cycle pulse, coincident with `done`, when a reserved code was issued.

## Operation
- FSM has three states: IDLE → EXEC → WB → IDLE.
- **IDLE**
  - `instr_ready` = 1.
  - On `instr_valid & instr_ready`, latch code and rd, latch `reg[rs]` into `cmp_a` and `reg[rt]` into `cmp_b`, then go to EXEC.
- **EXEC**
  - `instr_ready` = 0.
  - At the end of the cycle, capture `cmp_c` into `result`, except for codes 110/111: capture 16'h0000 and set the error flag.
  - Go to WB.
- **WB**
  - `instr_ready` = 0, `done` = 1, `err` = flag.
  - At the end of the cycle, write `result` into `reg[rd]`. Go to IDLE.
- Comparison is unsigned. The comparator result is only 16'h0000 or 16'h0001; the stage stores whatever `cmp_c` presents, unmodified.
- `cmp_a`, `cmp_b` and `cmp_code` hold their values from issue until the next issue.
- Register 0 is an ordinary register. rs = rt is legal, and rd may equal rs or rt.
- External writes
  - Honoured in every state.
  - Same edge, same address as a WB write: WB wins and the external write is dropped.
  - Different addresses: both writes commit.
- Operand read at issue sees register contents before that edge. An `ext_we` to rs on the issue edge is not forwarded.

## Timing
- Handshake at edge N:
  - EXEC during cycle N+1, `cmp_c` sampled at edge N+1.
  - WB during cycle N+2: `done`/`result` valid, `reg[rd]` updated at edge N+2.
  - `instr_ready` high again in cycle N+3.
- Latency is 3 cycles; throughput is one instruction per 3 cycles.
- There is no data hazard, because writeback completes before the next issue.
- `instr_valid` asserted outside IDLE is ignored. The producer holds the instruction until ready.
- Reset values, taken at any `clk` edge with `rst_n` = 0:
  - state = IDLE, all registers = 0;
  - `cmp_a` = `cmp_b` = 0, `cmp_code` = 0, `result` = 0;
  - `done` = 0, `err` = 0, `instr_ready` = 1 in the cycle after reset.
- Reset mid-operation, in EXEC or WB, abandons the instruction: no register write, no `done`.

## Structure
- Shared package `alu_pkg`:
  - `cond_code_t` enum (LE, LT, GE, GT, EQ, NE, RSV6, RSV7);
  - `DW` and `NREG` constants;
  - `REG_AW` address-width constant;
  - `issue_state_t` enum (IDLE, EXEC, WB).
- One sub-module, `cond_regfile`: an NREG×DW register file with two combinational read ports (operand, debug) and two synchronous write ports with WB priority.
- The comparator is instantiated beside this block, not inside it.

## Test plan
- Load r1 = 16'h0005 and r2 = 16'h0009. Issue LT rs=1, rt=2, rd=3 → `done` in cycle N+2, `result` = 1, r3 = 16'h0001 afterwards.
- Issue GT with the same operands, rd=3 → r3 = 16'h0000. Then issue EQ rs=1, rt=1, rd=4 → r4 = 1.
- Issue code 110 → `err` and `done` pulse together, rd written to 0, `cmp_code` = 110.
- Issue with `ext_we` to rd asserted on the WB edge → rd holds the comparator result. `ext_we` to another register on the same edge → both writes land.
- Hold `instr_valid` high continuously → exactly one accept every 3 cycles; `instr_ready` low in EXEC and WB.
- Assert `rst_n` = 0 during EXEC → no `done`, all registers read 0 via `dbg_rdata`, `instr_ready` = 1 in the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the lab ALU datapath.
//   cond_code_t   : comparator condition codes (6 real, 2 reserved)
//   issue_state_t : issue/writeback stage FSM states
//   DW, NREG      : data width and register count
//   REG_AW        : register address width
package alu_pkg;

  localparam int DW     = 16;
  localparam int NREG   = 8;
  localparam int REG_AW = $clog2(NREG);

  typedef enum logic [2:0] {
    LE   = 3'b000,
    LT   = 3'b001,
    GE   = 3'b010,
    GT   = 3'b011,
    EQ   = 3'b100,
    NE   = 3'b101,
    RSV6 = 3'b110,
    RSV7 = 3'b111
  } cond_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } issue_state_t;

  function automatic logic is_reserved(input cond_code_t code);
    return (code == RSV6) || (code == RSV7);
  endfunction

endpackage

// File: rtl/cond_regfile.sv
// NREG x DW register file for the condition issue stage.
//   clk_i, rst_n_i          : clock, synchronous active-low reset (clears all)
//   rs_addr_i/rs_data_o,
//   rt_addr_i/rt_data_o     : operand read port (two lanes), combinational
//   dbg_addr_i/dbg_data_o   : debug read port, combinational
//   wb_we_i/wb_addr_i/wb_data_i    : writeback write port (priority)
//   ext_we_i/ext_addr_i/ext_data_i : external write port
module cond_regfile #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [AW-1:0] rs_addr_i,
  output logic [DW-1:0] rs_data_o,
  input  logic [AW-1:0] rt_addr_i,
  output logic [DW-1:0] rt_data_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_o,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic          ext_we_i,
  input  logic [AW-1:0] ext_addr_i,
  input  logic [DW-1:0] ext_data_i
);

  logic [DW-1:0] regs_q [NREG];

  assign rs_data_o  = regs_q[rs_addr_i];
  assign rt_data_o  = regs_q[rt_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

  // Writeback beats the external port on an address collision; writes to
  // distinct addresses both land on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (wb_we_i && (wb_addr_i == AW'(i))) begin
          regs_q[i] <= wb_data_i;
        end else if (ext_we_i && (ext_addr_i == AW'(i))) begin
          regs_q[i] <= ext_data_i;
        end
      end
    end
  end

endmodule

// File: rtl/cond_issue_stage.sv
// Issue/writeback stage feeding the external set_condition comparator.
// Accepts a compare instruction (valid/ready), reads rs/rt from the internal
// register file into registered comparator operands, captures the comparator
// result one cycle later and writes it back to rd in the following cycle.
//   clk, rst_n                       : clock, synchronous active-low reset
//   instr_valid/instr_ready          : instruction handshake
//   instr_code/rs/rt/rd              : condition code and register indices
//   ext_we/ext_waddr/ext_wdata       : side write port into the register file
//   dbg_raddr/dbg_rdata              : combinational debug read port
//   cmp_a/cmp_b/cmp_code             : registered comparator inputs
//   cmp_c                            : comparator result
//   done/result/err                  : writeback pulse, held result, reserved-code flag
module cond_issue_stage #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [2:0]              instr_code,
  input  logic [$clog2(NREG)-1:0] instr_rs,
  input  logic [$clog2(NREG)-1:0] instr_rt,
  input  logic [$clog2(NREG)-1:0] instr_rd,
  input  logic                    ext_we,
  input  logic [$clog2(NREG)-1:0] ext_waddr,
  input  logic [DW-1:0]           ext_wdata,
  input  logic [$clog2(NREG)-1:0] dbg_raddr,
  output logic [DW-1:0]           dbg_rdata,
  output logic [DW-1:0]           cmp_a,
  output logic [DW-1:0]           cmp_b,
  output logic [2:0]              cmp_code,
  input  logic [DW-1:0]           cmp_c,
  output logic                    done,
  output logic [DW-1:0]           result,
  output logic                    err
);

  import alu_pkg::*;

  localparam int AW = $clog2(NREG);

  issue_state_t  state_q, state_d;
  logic [DW-1:0] cmp_a_q, cmp_a_d;
  logic [DW-1:0] cmp_b_q, cmp_b_d;
  cond_code_t    code_q, code_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] result_q, result_d;
  logic          err_q, err_d;

  logic [DW-1:0] rs_data, rt_data;
  logic          wb_we;

  cond_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rs_addr_i  (instr_rs),
    .rs_data_o  (rs_data),
    .rt_addr_i  (instr_rt),
    .rt_data_o  (rt_data),
    .dbg_addr_i (dbg_raddr),
    .dbg_data_o (dbg_rdata),
    .wb_we_i    (wb_we),
    .wb_addr_i  (rd_q),
    .wb_data_i  (result_q),
    .ext_we_i   (ext_we),
    .ext_addr_i (ext_waddr),
    .ext_data_i (ext_wdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmp_a_q  <= '0;
      cmp_b_q  <= '0;
      code_q   <= LE;
      rd_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmp_a_q  <= cmp_a_d;
      cmp_b_q  <= cmp_b_d;
      code_q   <= code_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    code_d      = code_q;
    rd_d        = rd_q;
    result_d    = result_q;
    err_d       = err_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    wb_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          // Operands come from the pre-edge register contents; a same-edge
          // external write to rs/rt is deliberately not forwarded.
          cmp_a_d = rs_data;
          cmp_b_d = rt_data;
          code_d  = cond_code_t'(instr_code);
          rd_d    = instr_rd;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_reserved(code_q)) begin
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          result_d = cmp_c;
          err_d    = 1'b0;
        end
        state_d = WB;
      end
      WB: begin
        done    = 1'b1;
        err     = err_q;
        wb_we   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmp_a    = cmp_a_q;
  assign cmp_b    = cmp_b_q;
  assign cmp_code = code_q;
  assign result   = result_q;

endmodule
